// File: rtl/mem_mfc_responder.sv
// Responder end of the MFA/MFC memory handshake: big-endian byte-addressed RAM
// that raises MFC a programmable number of wait states after accepting a request.
module mem_mfc_responder #(
   parameter int ADDR_W      = 8,
   parameter int WAIT_STATES = 2
) (
   input  logic              CLK,
   input  logic              CLR,
   input  logic              MFA,
   input  logic              RW,
   input  logic [1:0]        TYPE,
   input  logic [ADDR_W-1:0] Address,
   input  logic [31:0]       DataIn,
   output logic [31:0]       DataOut,
   output logic              MFC
);

   localparam logic [3:0] LP_WAIT = 4'(WAIT_STATES);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

   logic [7:0] Mem [0:2**ADDR_W-1];

   state_t            r_state, w_next;
   logic [3:0]        r_cnt;
   logic              r_rw;
   logic [1:0]        r_type;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_wdata;
   logic [31:0]       r_dout;

   logic              w_access;
   logic [ADDR_W-1:0] w_a0, w_a1, w_a2, w_a3;
   logic [31:0]       w_rdata;

   // Alignment is applied silently to the latched address; index math wraps.
   always_comb begin
      w_a0 = r_addr;
      if (r_type == 2'b10)      w_a0 = {r_addr[ADDR_W-1:2], 2'b00};
      else if (r_type == 2'b01) w_a0 = {r_addr[ADDR_W-1:1], 1'b0};
      w_a1 = w_a0 + ADDR_W'(1);
      w_a2 = w_a0 + ADDR_W'(2);
      w_a3 = w_a0 + ADDR_W'(3);
   end

   always_comb begin
      case (r_type)
         2'b00:   w_rdata = {24'b0, Mem[w_a0]};
         2'b01:   w_rdata = {16'b0, Mem[w_a0], Mem[w_a1]};
         2'b10:   w_rdata = {Mem[w_a0], Mem[w_a1], Mem[w_a2], Mem[w_a3]};
         default: w_rdata = 32'b0;
      endcase
   end

   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // Dropping MFA in WAIT takes priority over a pending access.
   always_comb begin
      w_next   = r_state;
      w_access = 1'b0;
      case (r_state)
         S_IDLE: if (MFA) w_next = S_WAIT;
         S_WAIT: begin
            if (!MFA) begin
               w_next = S_IDLE;
            end else if (r_cnt == 4'd0) begin
               w_access = 1'b1;
               w_next   = S_DONE;
            end
         end
         S_DONE: if (!MFA) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         r_cnt   <= 4'd0;
         r_rw    <= 1'b0;
         r_type  <= 2'b00;
         r_addr  <= '0;
         r_wdata <= 32'b0;
         r_dout  <= 32'b0;
      end else begin
         if (r_state == S_IDLE && MFA) begin
            r_cnt   <= LP_WAIT;
            r_rw    <= RW;
            r_type  <= TYPE;
            r_addr  <= Address;
            r_wdata <= DataIn;
         end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
         end
         if (w_access && !r_rw) r_dout <= w_rdata;
      end
   end

   // Storage is deliberately outside the reset domain so contents survive CLR.
   always_ff @(posedge CLK) begin
      if (w_access && r_rw) begin
         case (r_type)
            2'b00: Mem[w_a0] <= r_wdata[7:0];
            2'b01: begin
               Mem[w_a0] <= r_wdata[15:8];
               Mem[w_a1] <= r_wdata[7:0];
            end
            2'b10: begin
               Mem[w_a0] <= r_wdata[31:24];
               Mem[w_a1] <= r_wdata[23:16];
               Mem[w_a2] <= r_wdata[15:8];
               Mem[w_a3] <= r_wdata[7:0];
            end
            default: ;
         endcase
      end
   end

   assign MFC     = (r_state == S_DONE);
   assign DataOut = r_dout;

endmodule
